// File: rtl/operand_fetch_pkg.sv
// Shared CPU header for the operand fetch stage: widths, enable levels and bubble values.
package operand_fetch_pkg;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = $clog2(REG_NUM);
    localparam int WORD_W     = 32;
    localparam int CNT_W      = 16;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic BUBBLE_VALID   = DISABLE;
    localparam logic BUBBLE_WE      = DISABLE;
    localparam logic BUBBLE_IS_LOAD = DISABLE;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/operand_fetch_mux.sv
// Single-source operand select: EX over MEM over register file, plus match flags.
// Forwarding paths exist only when OPERAND_FETCH_FORWARD_EN is defined.
module operand_mux
    import operand_fetch_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr_i,
    input  logic [WORD_W-1:0]     gpr_data_i,
    input  logic                  ex_we_i,
    input  logic [REG_ADDR_W-1:0] ex_addr_i,
    input  logic [WORD_W-1:0]     ex_data_i,
    input  logic                  mem_we_i,
    input  logic [REG_ADDR_W-1:0] mem_addr_i,
    input  logic [WORD_W-1:0]     mem_data_i,
    output logic [WORD_W-1:0]     op_o,
    output logic                  ex_match_o,
    output logic                  mem_match_o
);
    // r0 is an ordinary register here, so no zero-address exclusion.
    assign ex_match_o  = ex_we_i  && (ex_addr_i  == rs_addr_i);
    assign mem_match_o = mem_we_i && (mem_addr_i == rs_addr_i);

`ifdef OPERAND_FETCH_FORWARD_EN
    always_comb begin
        op_o = gpr_data_i;
        if (ex_match_o) begin
            op_o = ex_data_i;
        end else if (mem_match_o) begin
            op_o = mem_data_i;
        end
    end
`else
    assign op_o = gpr_data_i;
    logic unused_fwd_data;
    assign unused_fwd_data = ^{ex_data_i, mem_data_i};
`endif
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: operand select, load-use/forward hazard bubbles, stall counter.
// OPERAND_FETCH_FORWARD_EN enables EX/MEM forwarding; otherwise any pending write is a hazard.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    input  logic [REG_ADDR_W-1:0] if_rs0,
    input  logic [REG_ADDR_W-1:0] if_rs1,
    input  logic [REG_ADDR_W-1:0] if_rd,
    input  logic                  if_we,
    input  logic                  if_is_load,
    output logic [REG_ADDR_W-1:0] gpr_rd_addr_0,
    output logic [REG_ADDR_W-1:0] gpr_rd_addr_1,
    input  logic [WORD_W-1:0]     gpr_rd_data_0,
    input  logic [WORD_W-1:0]     gpr_rd_data_1,
    input  logic                  ex_fwd_we,
    input  logic                  ex_fwd_is_load,
    input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
    input  logic [WORD_W-1:0]     ex_fwd_data,
    input  logic                  mem_fwd_we,
    input  logic [REG_ADDR_W-1:0] mem_fwd_addr,
    input  logic [WORD_W-1:0]     mem_fwd_data,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  id_valid,
    output logic [WORD_W-1:0]     id_op0,
    output logic [WORD_W-1:0]     id_op1,
    output logic [REG_ADDR_W-1:0] id_rd,
    output logic                  id_we,
    output logic                  id_is_load,
    output logic                  stall_req,
    output logic [CNT_W-1:0]      stall_cnt
);
    logic [WORD_W-1:0] op0_sel, op1_sel;
    logic ex_match0, ex_match1, mem_match0, mem_match1;
    logic hazard;

    logic                  valid_q, valid_d;
    logic [WORD_W-1:0]     op0_q, op0_d;
    logic [WORD_W-1:0]     op1_q, op1_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  we_q, we_d;
    logic                  ld_q, ld_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    assign gpr_rd_addr_0 = if_rs0;
    assign gpr_rd_addr_1 = if_rs1;

    operand_mux u_mux0 (
        .rs_addr_i   (if_rs0),
        .gpr_data_i  (gpr_rd_data_0),
        .ex_we_i     (ex_fwd_we),
        .ex_addr_i   (ex_fwd_addr),
        .ex_data_i   (ex_fwd_data),
        .mem_we_i    (mem_fwd_we),
        .mem_addr_i  (mem_fwd_addr),
        .mem_data_i  (mem_fwd_data),
        .op_o        (op0_sel),
        .ex_match_o  (ex_match0),
        .mem_match_o (mem_match0)
    );

    operand_mux u_mux1 (
        .rs_addr_i   (if_rs1),
        .gpr_data_i  (gpr_rd_data_1),
        .ex_we_i     (ex_fwd_we),
        .ex_addr_i   (ex_fwd_addr),
        .ex_data_i   (ex_fwd_data),
        .mem_we_i    (mem_fwd_we),
        .mem_addr_i  (mem_fwd_addr),
        .mem_data_i  (mem_fwd_data),
        .op_o        (op1_sel),
        .ex_match_o  (ex_match1),
        .mem_match_o (mem_match1)
    );

`ifdef OPERAND_FETCH_FORWARD_EN
    // Only a load in EX cannot be forwarded in time.
    assign hazard = if_valid && ex_fwd_is_load && (ex_match0 || ex_match1);
    logic unused_mem_match;
    assign unused_mem_match = mem_match0 | mem_match1;
`else
    assign hazard = if_valid && (ex_match0 || ex_match1 || mem_match0 || mem_match1);
    logic unused_is_load;
    assign unused_is_load = ex_fwd_is_load;
`endif

    // Not gated by reset: the request tracks the live inputs only.
    assign stall_req = !flush && (stall_in || hazard);

    always_comb begin
        valid_d = valid_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        rd_d    = rd_q;
        we_d    = we_q;
        ld_d    = ld_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = BUBBLE_VALID;
            we_d    = BUBBLE_WE;
            ld_d    = BUBBLE_IS_LOAD;
        end else if (!stall_in) begin
            if (hazard) begin
                valid_d = BUBBLE_VALID;
                we_d    = BUBBLE_WE;
                ld_d    = BUBBLE_IS_LOAD;
                cnt_d   = sat_inc(cnt_q);
            end else begin
                valid_d = if_valid;
                op0_d   = op0_sel;
                op1_d   = op1_sel;
                rd_d    = if_rd;
                we_d    = if_valid && if_we;
                ld_d    = if_valid && if_is_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= BUBBLE_VALID;
            op0_q   <= '0;
            op1_q   <= '0;
            rd_q    <= '0;
            we_q    <= BUBBLE_WE;
            ld_q    <= BUBBLE_IS_LOAD;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign id_valid   = valid_q;
    assign id_op0     = op0_q;
    assign id_op1     = op1_q;
    assign id_rd      = rd_q;
    assign id_we      = we_q;
    assign id_is_load = ld_q;
    assign stall_cnt  = cnt_q;
endmodule
